keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan sequencer and debouncer for the 4x4 matrix keypad. It drives one column at a time and samples the four row inputs after a settle interval. Each full four-column frame is reduced to "no key", "one key" or "several keys", and the result is filtered over consecutive frames. Output is a one-cycle key event with a 4-bit code, which feeds the seven-segment decoder and downstream key consumers.

## Interface
- SETTLE_CYCLES, default 16: cycles a column is driven before its rows are sampled; must be ≥ 3.
- DEBOUNCE_SCANS, default 4: consecutive identical frames needed to accept a result; range 1..15.
- REPEAT_DELAY_SCANS, default 32: frames before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE_SCANS, default 8: frames between later auto-repeats; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- scan_en  in  1  level; high runs scanning.
- rows  in  4  row sense lines, active-high, asynchronous; a 2-flop synchronizer is inside the block.
- cols  out  4  column drive, one-hot active-high; 0 when idle.
- counter_cols  out  2  index of the column currently driven.
- key  out  4  last accepted key code, {row_idx, col_idx}.
- key_valid  out  1  one-cycle strobe; key is valid in the same cycle.
- key_held  out  1  high while the accepted single key stays debounced-pressed.
- multi_key  out  1  high while a debounced multi-key result is active.

## Operation
FSM states:
- IDLE: cols = 0. Move to DRIVE with column 0 when scan_en = 1.
- DRIVE: drive cols = 1 << counter_cols for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle. Synchronized rows are ORed into the frame accumulator for this column.
  - Column < 3: increment the column and return to DRIVE.
  - Column 3: go to EVAL.
- EVAL: one cycle. Classify the frame, update the debounce filter, clear the accumulator, return to DRIVE with column 0.

Frame classification:
- NONE: zero asserted row/column intersections.
- SINGLE: exactly one intersection. Code = row_idx*4 + col_idx; row 0 is rows[0], column 0 is cols[0].
- MULTI: two or more intersections, including two rows in one column.

Debounce filter:
- State: candidate result (class plus code), 4-bit saturating count, reported flag.
- Frame equals candidate: count increments and saturates at 15.
- Frame differs: candidate takes the new result and count = 1.
- Acceptance is evaluated when count == DEBOUNCE_SCANS:
  - SINGLE and not reported: key ← code, key_valid pulses, key_held = 1, reported = 1.
  - NONE: key_held = 0, multi_key = 0, reported = 0 (re-arm).
  - MULTI: multi_key = 1, key_held = 0, reported = 1. No key_valid until a debounced NONE.
- A change from one single key straight to another single key (no NONE between) produces no event until a release is debounced.
- key keeps its last value across releases.

scan_en and reset behaviour:
- scan_en falls in any state: go to IDLE on the next cycle, cols = 0. The partial frame and the filter are cleared; key_held, multi_key and reported are cleared; key is kept.
- Reset values: state IDLE, cols 0, counter_cols 0, key 0, key_valid 0, key_held 0, multi_key 0, filter cleared, synchronizer flops 0.

## Timing
- Column slot = SETTLE_CYCLES + 1 cycles.
- Frame = 4*(SETTLE_CYCLES+1) + 1 cycles; 69 at the defaults.
- key_valid asserts the cycle after the EVAL of the DEBOUNCE_SCANS-th matching frame.
- First-frame latency from scan_en rising: 1 cycle in IDLE, then one frame.
- A press that lands mid-frame may be seen in that frame or not; the requirement is DEBOUNCE_SCANS full matching frames.
- key_valid is never high for two consecutive cycles.
- cols and counter_cols are registered outputs.

## Configuration
Macro KEYPAD_REPEAT_EN.

Defined:
- While key_held = 1, a frame counter runs from acceptance.
- Extra key_valid pulses (same key) come REPEAT_DELAY_SCANS frames after acceptance, then every REPEAT_RATE_SCANS frames.
- The counter resets on release, multi-key or scan_en low.

Undefined:
- Exactly one key_valid per debounced press; the repeat counter and both repeat parameters are absent.

## Structure
- keypad_pkg holds:
  - constants NUM_ROWS = 4, NUM_COLS = 4, KEY_W = 4;
  - enum frame_class_t {FRAME_NONE, FRAME_SINGLE, FRAME_MULTI};
  - scan FSM state enum.
- Sub-module keypad_debounce: takes class, code and a frame strobe; outputs key_valid, key, key_held, multi_key, plus the optional repeat logic.
- keypad_scan_ctrl holds the synchronizer, the scan FSM and the frame accumulator.

## Test plan
Benches run with SETTLE_CYCLES = 4, DEBOUNCE_SCANS = 3.
- Reset, then scan_en = 1 with no keys: cols cycles 0001→0010→0100→1000, each column driven for 5 cycles, 21-cycle frame; key_valid never asserts; all outputs match reset values during reset.
- Row 2 active while cols[1] is driven, held 6 frames: exactly one key_valid with key = 4'h9, key_held = 1. Release for 3 frames: key_held = 0, key stays 9.
- Bounce press alternating pressed/open each frame for 6 frames, then stable: no key_valid until 3 stable frames.
- Keys 0 and 5 pressed together for 4 frames: multi_key = 1, no key_valid. Release key 5: still no event. Full release, then press key 5: key_valid with key = 5.
- scan_en dropped mid-frame with a 2-frame candidate in progress: cols = 0 next cycle, key_held = 0. Re-enable: 3 fresh frames required before key_valid.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY_SCANS = 4, REPEAT_RATE_SCANS = 2: key 3 held 12 frames gives pulses at acceptance, +4 frames, then every 2 frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and enumerations for the 4x4 keypad scanner and its debounce filter.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EVAL
  } scan_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce filter: accepts a frame result after DEBOUNCE_SCANS identical frames.
// Optional auto-repeat of the held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 32,
  parameter int REPEAT_RATE_SCANS  = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_strobe,
  input  logic [1:0]       frame_class,
  input  logic [KEY_W-1:0] frame_code,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             key_held,
  output logic             multi_key
);

  logic [1:0]       cand_class;
  logic [KEY_W-1:0] cand_code;
  logic [3:0]       count;
  logic [3:0]       count_next;
  logic             reported;
  logic             accept;

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep_cnt;
  logic [7:0] rep_cnt_next;
  logic       rep_first;
  logic [7:0] rep_target;
`endif

  always_comb begin
    count_next = 4'd1;
    if (frame_class == cand_class && frame_code == cand_code) begin
      count_next = (count == 4'hF) ? count : count + 4'd1;
    end
    accept = (count_next == 4'(DEBOUNCE_SCANS));
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next = rep_cnt + 8'd1;
    rep_target   = rep_first ? 8'(REPEAT_DELAY_SCANS) : 8'(REPEAT_RATE_SCANS);
`endif
  end

  // A scan_en drop clears the filter like reset but keeps the last accepted key.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_class <= FRAME_NONE;
      cand_code  <= '0;
      count      <= '0;
      reported   <= 1'b0;
      key_valid  <= 1'b0;
      key        <= '0;
      key_held   <= 1'b0;
      multi_key  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
      rep_first  <= 1'b1;
`endif
    end else if (clear) begin
      cand_class <= FRAME_NONE;
      cand_code  <= '0;
      count      <= '0;
      reported   <= 1'b0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_key  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
      rep_first  <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_strobe) begin
        cand_class <= frame_class;
        cand_code  <= frame_code;
        count      <= count_next;
`ifdef KEYPAD_REPEAT_EN
        if (key_held) begin
          if (rep_cnt_next == rep_target) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt_next;
          end
        end
`endif
        if (accept) begin
          if (frame_class == FRAME_SINGLE) begin
            if (!reported) begin
              key       <= frame_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              reported  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end
          end else begin
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= (frame_class == FRAME_MULTI);
            reported  <= (frame_class == FRAME_MULTI);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scan sequencer with row synchronizer and frame accumulator for a 4x4 keypad.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 32,
  parameter int REPEAT_RATE_SCANS  = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [1:0]          counter_cols,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  scan_state_t state, state_next;
  logic [1:0]                         col_next;
  logic [SW-1:0]                      settle_cnt, settle_next;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  acc, acc_next;
  logic [NUM_COLS-1:0]                cols_next;
  logic [NUM_ROWS-1:0]                rows_meta, rows_sync;
  frame_class_t                       fr_class;
  logic [KEY_W-1:0]                   fr_code;
  logic [KEY_W-1:0]                   hit_code;
  logic [4:0]                         hits;

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta    <= '0;
      rows_sync    <= '0;
      state        <= ST_IDLE;
      counter_cols <= '0;
      settle_cnt   <= '0;
      acc          <= '0;
      cols         <= '0;
    end else begin
      rows_meta    <= rows;
      rows_sync    <= rows_meta;
      state        <= state_next;
      counter_cols <= col_next;
      settle_cnt   <= settle_next;
      acc          <= acc_next;
      cols         <= cols_next;
    end
  end

  // cols is registered from the next-state decision so it always matches the state.
  always_comb begin
    state_next  = state;
    col_next    = counter_cols;
    settle_next = settle_cnt;
    acc_next    = acc;
    cols_next   = '0;
    if (!scan_en) begin
      state_next  = ST_IDLE;
      col_next    = '0;
      settle_next = '0;
      acc_next    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next  = ST_DRIVE;
          col_next    = '0;
          settle_next = '0;
          cols_next   = 4'b0001;
        end
        ST_DRIVE: begin
          cols_next = 4'b0001 << counter_cols;
          if (settle_cnt == SETTLE_LAST) begin
            state_next  = ST_SAMPLE;
            settle_next = '0;
          end else begin
            settle_next = settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          acc_next[counter_cols] = acc[counter_cols] | rows_sync;
          if (counter_cols == 2'd3) begin
            state_next = ST_EVAL;
          end else begin
            state_next = ST_DRIVE;
            col_next   = counter_cols + 2'd1;
            cols_next  = 4'b0001 << (counter_cols + 2'd1);
          end
        end
        default: begin
          acc_next   = '0;
          state_next = ST_DRIVE;
          col_next   = '0;
          cols_next  = 4'b0001;
        end
      endcase
    end
  end

  // Count intersections in the finished frame; the code is only meaningful for a single hit.
  always_comb begin
    hits     = '0;
    hit_code = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (acc[c][r]) begin
          hits     = hits + 5'd1;
          hit_code = KEY_W'(r * NUM_COLS + c);
        end
      end
    end
    fr_class = (hits == 5'd0) ? FRAME_NONE : (hits == 5'd1) ? FRAME_SINGLE : FRAME_MULTI;
    fr_code  = (hits == 5'd1) ? hit_code : '0;
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS     (DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY_SCANS (REPEAT_DELAY_SCANS),
    .REPEAT_RATE_SCANS  (REPEAT_RATE_SCANS)
`endif
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .clear        (~scan_en),
    .frame_strobe (state == ST_EVAL),
    .frame_class  (fr_class),
    .frame_code   (fr_code),
    .key_valid    (key_valid),
    .key          (key),
    .key_held     (key_held),
    .multi_key    (multi_key)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a physical keypad model drives rows, and a
// frame-level reference model predicts key events; honours KEYPAD_REPEAT_EN if defined.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int RDELAY = 4;
  localparam int RRATE  = 2;
  localparam int FRAME_LEN = 4 * (SETTLE + 1) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [1:0]  counter_cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

  // Reference model state, one update per scanned frame.
  int m_cls, m_code, m_cnt, m_key, m_since;
  bit m_rep, m_held, m_multi, exp_kv;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES      (SETTLE),
    .DEBOUNCE_SCANS     (DEB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY_SCANS (RDELAY),
    .REPEAT_RATE_SCANS  (RRATE)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_en      (scan_en),
    .rows         (rows),
    .cols         (cols),
    .counter_cols (counter_cols),
    .key          (key),
    .key_valid    (key_valid),
    .key_held     (key_held),
    .multi_key    (multi_key)
  );

  always #5 clk = ~clk;

  // Switch matrix: a row line is high when its switch in the driven column is closed.
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (cols[c] && pressed[r*4+c]) rows[r] = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    m_cls = 0; m_code = 0; m_cnt = 0; m_rep = 0;
    m_held = 0; m_multi = 0; m_since = 0;
  endtask

  task automatic modelFrame(input logic [15:0] mask);
    int pop, cls, code;
    bit clears;
    pop  = $countones(mask);
    cls  = (pop == 0) ? 0 : (pop == 1) ? 1 : 2;
    code = 0;
    if (pop == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) code = i;
    if (cls == m_cls && code == m_code) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    else begin m_cls = cls; m_code = code; m_cnt = 1; end
    exp_kv = 0;
    clears = (m_cnt == DEB) && (cls != 1);
`ifdef KEYPAD_REPEAT_EN
    if (m_held && !clears) begin
      m_since++;
      if (m_since == RDELAY || (m_since > RDELAY && (m_since - RDELAY) % RRATE == 0)) exp_kv = 1;
    end
`else
    if (clears) m_since = 0;
`endif
    if (m_cnt == DEB) begin
      if (cls == 1 && !m_rep) begin
        m_key = code; exp_kv = 1; m_held = 1; m_rep = 1; m_since = 0;
      end else if (cls == 0) begin
        m_held = 0; m_multi = 0; m_rep = 0;
      end else if (cls == 2) begin
        m_multi = 1; m_held = 0; m_rep = 1;
      end
    end
  endtask

  // Wait for the first column drive after enabling the scan.
  task automatic waitStart();
    logic [3:0] last;
    bit done;
    last = cols; done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cols == 4'b0001 && last != 4'b0001) done = 1;
      last = cols;
    end
    checkOutput("start_seen", done, 1);
    checkOutput("start_kv", key_valid, 0);
  endtask

  // Called at the first cycle of a frame; holds mask for one frame and checks its result.
  task automatic applyStimulus(input logic [15:0] mask);
    int n0, n1, n2, n3, nz, nbad, kv_in, n;
    logic [3:0] last;
    bit done;
    pressed = mask;
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; nz = 0; nbad = 0; kv_in = 0; n = 0; done = 0;
    checkOutput("ccol_start", counter_cols, 0);
    last = cols;
    for (int i = 0; i < 100 && !done; i++) begin
      case (last)
        4'b0001: n0++;
        4'b0010: n1++;
        4'b0100: n2++;
        4'b1000: n3++;
        4'b0000: nz++;
        default: nbad++;
      endcase
      @(negedge clk);
      n++;
      if (cols == 4'b0001 && last != 4'b0001) done = 1;
      else if (key_valid) kv_in++;
      last = cols;
    end
    modelFrame(mask);
    checkOutput("frame_len", n, FRAME_LEN);
    checkOutput("col_slots", {n0[7:0], n1[7:0], n2[7:0], n3[7:0]},
                {8'(SETTLE + 1), 8'(SETTLE + 1), 8'(SETTLE + 1), 8'(SETTLE + 1)});
    checkOutput("col_idle", {nz[7:0], nbad[7:0]}, {8'd1, 8'd0});
    checkOutput("kv_inside", kv_in, 0);
    checkOutput("key_valid", key_valid, exp_kv);
    checkOutput("key", key, m_key);
    checkOutput("key_held", key_held, m_held);
    checkOutput("multi_key", multi_key, m_multi);
  endtask

  task automatic holdFrames(input logic [15:0] mask, input int frames);
    for (int i = 0; i < frames; i++) applyStimulus(mask);
  endtask

  initial begin
    reset = 1'b1; scan_en = 1'b1; pressed = '0;
    m_key = 0; modelClear();
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_cols", cols, 0);
      checkOutput("rst_ccol", counter_cols, 0);
      checkOutput("rst_key", {key, key_valid, key_held, multi_key}, 0);
    end
    scan_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cols", cols, 0);
    scan_en = 1'b1;
    waitStart();

    // Idle keypad, then key 9 (row 2, column 1) held and released.
    holdFrames(16'h0000, 3);
    holdFrames(16'h0200, 6);
    holdFrames(16'h0000, 3);

    // Bouncing key 6 followed by a stable press.
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 16'h0040 : 16'h0000);
    holdFrames(16'h0040, 4);
    holdFrames(16'h0000, 3);

    // Keys 0 and 5 together, then only key 0, then full release and key 5 alone.
    holdFrames(16'h0021, 4);
    holdFrames(16'h0001, 4);
    holdFrames(16'h0000, 3);
    holdFrames(16'h0020, 3);
    holdFrames(16'h0000, 3);

    // Accepted key 9, then a 2-frame key 10 candidate interrupted by scan_en low.
    holdFrames(16'h0200, 4);
    holdFrames(16'h0400, 2);
    pressed = 16'h0400;
    repeat (8) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    modelClear();
    checkOutput("drop_cols", cols, 0);
    checkOutput("drop_held", key_held, 0);
    checkOutput("drop_multi", multi_key, 0);
    checkOutput("drop_key", key, m_key);
    repeat (3) @(negedge clk);
    scan_en = 1'b1;
    waitStart();
    holdFrames(16'h0400, 4);
    holdFrames(16'h0000, 3);

    // Key 3 held long enough to exercise auto-repeat when it is built in.
    holdFrames(16'h0008, 12);
    holdFrames(16'h0000, 3);

    // Random segments of none / one / two keys, each held for a few frames.
    for (int s = 0; s < 40; s++) begin
      int kind, k1, k2, len;
      logic [15:0] mask;
      kind = $urandom_range(0, 2);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + 1 + $urandom_range(0, 14)) % 16;
      len  = $urandom_range(1, 5);
      mask = '0;
      if (kind >= 1) mask[k1] = 1'b1;
      if (kind == 2) mask[k2] = 1'b1;
      holdFrames(mask, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
